// File: rtl/aha_tlx_fwd_credit_ctrl_pkg.sv
// aha_tlx_fwd_credit_ctrl_pkg: shared state encodings, widths and helpers for the TLX forward credit controller
package aha_tlx_fwd_credit_ctrl_pkg;
  localparam int TLX_CR_W = 3;
  typedef logic [1:0] tlx_state_t;
  localparam tlx_state_t ST_IDLE   = 2'd0;
  localparam tlx_state_t ST_ACTIVE = 2'd1;
  localparam tlx_state_t ST_DRAIN  = 2'd2;
  function automatic int credit_w(input int max_credits);
    return $clog2(max_credits + 1);
  endfunction
endpackage

// File: rtl/aha_tlx_fwd_credit_ctrl_if.sv
// aha_tlx_fwd_credit_ctrl_if: payload, credit-return and status signals of the TLX forward channel
interface aha_tlx_fwd_credit_ctrl_if
  import aha_tlx_fwd_credit_ctrl_pkg::*;
#(
  parameter int DATA_W      = 40,
  parameter int MAX_CREDITS = 16
);
  localparam int CW = credit_w(MAX_CREDITS);
  logic                LINK_EN;
  logic                S_TVALID;
  logic                S_TREADY;
  logic [DATA_W-1:0]   S_TDATA;
  logic                M_TVALID;
  logic                M_TREADY;
  logic [DATA_W-1:0]   M_TDATA;
  logic                CR_TVALID;
  logic                CR_TREADY;
  logic [TLX_CR_W-1:0] CR_TDATA;
  logic                LINK_ACTIVE;
  logic [CW-1:0]       CREDIT_CNT;
  logic                CREDIT_OVF;
  logic                DRAIN_TO;
  modport slave (
    input  LINK_EN, S_TVALID, S_TDATA, M_TREADY, CR_TVALID, CR_TDATA,
    output S_TREADY, M_TVALID, M_TDATA, CR_TREADY, LINK_ACTIVE, CREDIT_CNT, CREDIT_OVF, DRAIN_TO
  );
  modport master (
    output LINK_EN, S_TVALID, S_TDATA, M_TREADY, CR_TVALID, CR_TDATA,
    input  S_TREADY, M_TVALID, M_TDATA, CR_TREADY, LINK_ACTIVE, CREDIT_CNT, CREDIT_OVF, DRAIN_TO
  );
endinterface

// File: rtl/aha_tlx_fwd_credit_ctrl_reg_slice.sv
// aha_tlx_fwd_credit_ctrl_reg_slice: one-entry valid/data output register with ready back-pressure
module aha_tlx_fwd_credit_ctrl_reg_slice #(
  parameter int DATA_W = 40
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i
);
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  // load a new beat when offered, otherwise empty only on a downstream handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_valid_i) begin
      valid_q <= 1'b1;
      data_q  <= in_data_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: rtl/aha_tlx_fwd_credit_ctrl.sv
// aha_tlx_fwd_credit_ctrl: credit-gated forward payload path with link bring-up/drain sequencing
module aha_tlx_fwd_credit_ctrl
  import aha_tlx_fwd_credit_ctrl_pkg::*;
#(
  parameter int DATA_W        = 40,
  parameter int MAX_CREDITS   = 16,
  parameter int INIT_CREDITS  = 16,
  parameter int DRAIN_TIMEOUT = 1023
) (
  input logic                      TLX_SIB_CLK,
  input logic                      TLX_SIB_RESETn,
  aha_tlx_fwd_credit_ctrl_if.slave bus
);
  localparam int CW = credit_w(MAX_CREDITS);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CW:0]   MAX_V  = (CW+1)'(MAX_CREDITS);
  localparam logic [CW-1:0] INIT_V = CW'(INIT_CREDITS);
  localparam logic [TW-1:0] TO_V   = TW'(DRAIN_TIMEOUT);
  tlx_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ovf_q, ovf_d, to_q, to_d, cr_rdy_q;
  logic          slice_rdy, m_valid, s_rdy, consume, go_active, timeout;
  logic [CW:0]   sum;
  assign s_rdy     = state_q == ST_ACTIVE && cnt_q != '0 && slice_rdy;
  assign consume   = bus.S_TVALID && s_rdy;
  assign go_active = state_q == ST_IDLE && bus.LINK_EN;
  assign timeout   = state_q == ST_DRAIN && timer_q == TO_V;
  assign sum       = {1'b0, cnt_q} + (CW+1)'(bus.CR_TVALID ? bus.CR_TDATA : '0) - (CW+1)'(consume);
  aha_tlx_fwd_credit_ctrl_reg_slice #(.DATA_W(DATA_W)) u_slice (
    .clk_i       (TLX_SIB_CLK),
    .rst_ni      (TLX_SIB_RESETn),
    .in_valid_i  (consume),
    .in_data_i   (bus.S_TDATA),
    .in_ready_o  (slice_rdy),
    .out_valid_o (m_valid),
    .out_data_o  (bus.M_TDATA),
    .out_ready_i (bus.M_TREADY)
  );
  assign bus.S_TREADY    = s_rdy;
  assign bus.M_TVALID    = m_valid;
  assign bus.CR_TREADY   = cr_rdy_q;
  assign bus.LINK_ACTIVE = state_q == ST_ACTIVE;
  assign bus.CREDIT_CNT  = cnt_q;
  assign bus.CREDIT_OVF  = ovf_q;
  assign bus.DRAIN_TO    = to_q;
  // drain leaves only once the output slice is empty, whether by credits settling or by timeout
  always_comb begin
    state_d = go_active ? ST_ACTIVE :
              (state_q == ST_ACTIVE && !bus.LINK_EN) ? ST_DRAIN :
              (state_q == ST_DRAIN && !m_valid && (cnt_q == INIT_V || timeout)) ? ST_IDLE : state_q;
    cnt_d   = state_q == ST_IDLE ? INIT_V : sum > MAX_V ? MAX_V[CW-1:0] : sum[CW-1:0];
    ovf_d   = !go_active && (ovf_q || (state_q != ST_IDLE && sum > MAX_V));
    to_d    = !go_active && (to_q || timeout);
    timer_d = state_q != ST_DRAIN ? '0 : timeout ? timer_q : timer_q + TW'(1);
  end
  // controller state, credit counter, drain timer and sticky flags
  always_ff @(posedge TLX_SIB_CLK or negedge TLX_SIB_RESETn) begin
    if (!TLX_SIB_RESETn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= INIT_V;
      timer_q  <= '0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
      cr_rdy_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      ovf_q    <= ovf_d;
      to_q     <= to_d;
      cr_rdy_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_aha_tlx_fwd_credit_ctrl.sv
// tb_aha_tlx_fwd_credit_ctrl: scoreboard bench for the TLX forward credit controller
module tb_aha_tlx_fwd_credit_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          total = 0, bad = 0, n_acc = 0, n_out = 0;
  logic [39:0] sb_q[$];
  logic        hold_q = 1'b0;
  logic [39:0] hold_d = '0;
  aha_tlx_fwd_credit_ctrl_if bus ();
  aha_tlx_fwd_credit_ctrl dut (.TLX_SIB_CLK(clk), .TLX_SIB_RESETn(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    bus.S_TDATA = {8'($urandom()), 32'($urandom())};
  endtask
  task automatic ret(input int n);
    bus.CR_TVALID = 1'b1;
    bus.CR_TDATA  = 3'(n);
    tick();
    bus.CR_TVALID = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        chk("hold_valid", bus.M_TVALID, 1);
        chk("hold_data", bus.M_TDATA, hold_d);
      end
      if (bus.M_TVALID && bus.M_TREADY) begin
        n_out++;
        chk("sb_pending", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) chk("sb_data", bus.M_TDATA, sb_q.pop_front());
      end
      if (bus.S_TVALID && bus.S_TREADY) begin
        n_acc++;
        sb_q.push_back(bus.S_TDATA);
      end
      hold_q = bus.M_TVALID && !bus.M_TREADY;
      hold_d = bus.M_TDATA;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n;
    bus.LINK_EN = 0; bus.S_TVALID = 0; bus.S_TDATA = '0;
    bus.M_TREADY = 1; bus.CR_TVALID = 0; bus.CR_TDATA = '0;
    repeat (2) tick();
    chk("rst_s_tready", bus.S_TREADY, 0);
    chk("rst_m_tvalid", bus.M_TVALID, 0);
    chk("rst_m_tdata", bus.M_TDATA, 0);
    chk("rst_cr_tready", bus.CR_TREADY, 0);
    chk("rst_link_active", bus.LINK_ACTIVE, 0);
    chk("rst_credit_cnt", bus.CREDIT_CNT, 16);
    chk("rst_ovf", bus.CREDIT_OVF, 0);
    chk("rst_drain_to", bus.DRAIN_TO, 0);
    rst_n = 1;
    tick();
    chk("cr_tready_up", bus.CR_TREADY, 1);
    chk("idle_link_active", bus.LINK_ACTIVE, 0);
    bus.LINK_EN = 1;
    tick();
    chk("t1_active", bus.LINK_ACTIVE, 1);
    chk("t1_cnt_init", bus.CREDIT_CNT, 16);
    bus.S_TVALID = 1;
    repeat (16) tick();
    chk("t1_acc16", n_acc, 16);
    chk("t1_cnt0", bus.CREDIT_CNT, 0);
    chk("t1_s_tready0", bus.S_TREADY, 0);
    repeat (4) tick();
    chk("t1_acc_stays", n_acc, 16);
    chk("t1_out16", n_out, 16);
    chk("t1_sb_empty", sb_q.size(), 0);
    ret(3);
    chk("t2_cnt3", bus.CREDIT_CNT, 3);
    repeat (5) tick();
    chk("t2_acc19", n_acc, 19);
    chk("t2_cnt0", bus.CREDIT_CNT, 0);
    bus.S_TVALID = 0;
    tick();
    chk("t2_out19", n_out, 19);
    ret(5);
    chk("t3_cnt5", bus.CREDIT_CNT, 5);
    bus.S_TVALID = 1;
    ret(2);
    bus.S_TVALID = 0;
    chk("t3_cnt6", bus.CREDIT_CNT, 6);
    chk("t3_acc20", n_acc, 20);
    ret(7);
    ret(1);
    chk("t4_cnt14", bus.CREDIT_CNT, 14);
    chk("t4_ovf0", bus.CREDIT_OVF, 0);
    ret(7);
    chk("t4_cnt_sat", bus.CREDIT_CNT, 16);
    chk("t4_ovf1", bus.CREDIT_OVF, 1);
    repeat (3) tick();
    chk("t4_ovf_sticky", bus.CREDIT_OVF, 1);
    bus.M_TREADY = 0;
    bus.S_TVALID = 1;
    tick();
    bus.S_TVALID = 0;
    chk("t5_m_pending", bus.M_TVALID, 1);
    chk("t5_cnt15", bus.CREDIT_CNT, 15);
    bus.LINK_EN = 0;
    tick();
    chk("t5_drain_inactive", bus.LINK_ACTIVE, 0);
    chk("t5_drain_s_tready", bus.S_TREADY, 0);
    chk("t5_drain_m_held", bus.M_TVALID, 1);
    repeat (3) tick();
    bus.M_TREADY = 1;
    tick();
    chk("t5_m_released", bus.M_TVALID, 0);
    chk("t5_out21", n_out, 21);
    ret(1);
    chk("t5_drain_ret", bus.CREDIT_CNT, 16);
    tick();
    chk("t5_drain_to0", bus.DRAIN_TO, 0);
    ret(5);
    chk("t5_idle_ignores_ret", bus.CREDIT_CNT, 16);
    chk("t5_idle_ovf_sticky", bus.CREDIT_OVF, 1);
    bus.LINK_EN = 1;
    tick();
    chk("t5_reactivated", bus.LINK_ACTIVE, 1);
    chk("t5_ovf_cleared", bus.CREDIT_OVF, 0);
    bus.S_TVALID = 1;
    tick();
    bus.S_TVALID = 0;
    chk("t6_cnt15", bus.CREDIT_CNT, 15);
    bus.LINK_EN = 0;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 500) bus.LINK_EN = 1;
    end while (!bus.DRAIN_TO && n < 1100);
    chk("t6_timeout_cycles", n, 1025);
    chk("t6_drain_to1", bus.DRAIN_TO, 1);
    chk("t6_not_active", bus.LINK_ACTIVE, 0);
    tick();
    chk("t6_reactivated", bus.LINK_ACTIVE, 1);
    chk("t6_drain_to_cleared", bus.DRAIN_TO, 0);
    chk("t6_cnt_init", bus.CREDIT_CNT, 16);
    bus.S_TVALID = 1;
    repeat (3) tick();
    chk("rst_mid_m_valid", bus.M_TVALID, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_m_tvalid", bus.M_TVALID, 0);
    chk("arst_m_tdata", bus.M_TDATA, 0);
    chk("arst_s_tready", bus.S_TREADY, 0);
    chk("arst_cr_tready", bus.CR_TREADY, 0);
    chk("arst_link_active", bus.LINK_ACTIVE, 0);
    chk("arst_credit_cnt", bus.CREDIT_CNT, 16);
    bus.S_TVALID = 0;
    tick();
    rst_n = 1;
    tick();
    chk("post_rst_cr_tready", bus.CR_TREADY, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
